pattern_scan_engine: RTL and testbench
======================================

Name: pattern_scan_engine

Overview:
- Hardware successor to the software pattern-search program.
- On a start pulse, it streams NBYTES bytes from a synchronous-read data memory, starting at a programmable base address.
- It compares each byte against a PAT_W-bit pattern and produces three counts:
  - matches wholly inside a byte;
  - bytes holding at least one match;
  - matches over the whole bitstream, including byte-crossing ones.
- Sits beside dm1 on its read port; the results are read by the top level / bench.

Parameters:
PAT_W, 5, pattern width in bits; legal range 1..8
NBYTES, 32, bytes scanned per run; >= 1
ADDR_W, 8, memory address width
CNT_W, 16, width of each count; must satisfy 2^CNT_W > 8*NBYTES (no saturation logic)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle run request
pat  in  PAT_W  pattern; sampled on accepted start
base  in  ADDR_W  first byte address; sampled on accepted start
mem_addr  out  ADDR_W  read address to data memory
mem_rd  out  1  read enable
mem_rdata  in  8  read data; valid one cycle after its address (synchronous read)
busy  out  1  high while scanning
done  out  1  level ack; high from scan completion until next accepted start
cnt_in  out  CNT_W  within-byte match count
cnt_byte  out  CNT_W  bytes with >=1 within-byte match
cnt_all  out  CNT_W  match count over the full 8*NBYTES-bit stream

Behaviour:
- Reset (reset low, async):
  - state IDLE;
  - busy=0, done=0, mem_rd=0, mem_addr=0;
  - all counts 0; internal index/pattern/tail registers 0.
  - Reset mid-scan aborts immediately; no partial results are retained.
- States IDLE, RUN, DONE.
  - start is accepted only in IDLE or DONE; it is ignored while busy.
  - Accept edge E0:
    - latch pat and base;
    - clear counts and done;
    - idx=0, busy=1;
    - state RUN.
- RUN:
  - mem_rd=1 and mem_addr=(base+idx) mod 2^ADDR_W for idx=0..NBYTES-1, one address per cycle; idx increments each edge.
  - Byte k is returned after the edge following its address and is processed on the next edge (pipelined, one byte per cycle).
  - After the last address is issued, mem_rd=0 and mem_addr holds its value.
- Completion:
  - the final byte is processed on edge E(NBYTES+1);
  - on that same edge the counts hold final values, busy->0, done->1, state DONE.
  - Latency is exactly NBYTES+1 edges from the accept edge.
- DONE: counts and done hold until reset or the next accepted start.
- Bit order:
  - the stream is byte 0 first, MSB first within each byte;
  - window k of a byte is bits [k+PAT_W-1:k], for k=0..8-PAT_W.
- Per processed byte b:
  - m = number of windows k with window == pat.
  - cnt_in += m.
  - cnt_byte += (m != 0).
  - cnt_all += m + c, where c counts only from the second byte on.
  - c counts the PAT_W-1 windows of the 16-bit concatenation {prev_byte, b} that straddle the boundary (span both bytes); c=0 for byte 0.
  - prev_byte tail register updates to b.
- Invariant: cnt_all counts all 8*NBYTES-PAT_W+1 stream positions.
- PAT_W=1: no straddling windows; cnt_all == cnt_in.
- PAT_W=8: exactly one in-byte window per byte.
- start and reset: reset dominates. A start held high in DONE re-runs every accept; the bench must pulse it.

Test Plan:
- Defaults, pat=5'b11111, all 32 bytes 0xFF, base=0 -> cnt_in=128, cnt_byte=32, cnt_all=252; done rises exactly 33 edges after accept.
- pat=5'b10101, all bytes 0x55 -> cnt_in=64, cnt_byte=32, cnt_all=126; pat=5'b00000 with all 0x00 -> 128/32/252.
- Boundary: byte0=0x03, byte1=0xE0, others 0x00, pat=5'b11111 -> cnt_in=0, cnt_byte=0, cnt_all=1. Then byte0=0xF8, rest 0x00 -> 1/1/1.
- Base wrap: base=8'hF0, NBYTES=32 -> mem_addr sequence F0..FF,00..0F; counts match an identical payload at base 0.
- PAT_W=3, NBYTES=4, pat=3'b111, bytes 0xFF -> cnt_in=24, cnt_byte=4, cnt_all=30, done after 5 edges.
- Control:
  - start pulsed mid-run -> ignored, results unchanged.
  - reset asserted at idx=10 -> outputs 0 asynchronously, state IDLE.
  - a fresh start after reset gives correct full results.
  - a second start from DONE clears done the next edge.

Source files
------------

// File: rtl/pattern_scan_engine.sv
// Streams NBYTES bytes from a synchronous-read memory and counts PAT_W-bit pattern
// matches inside bytes, bytes containing a match, and matches over the whole bitstream.
module pattern_scan_engine #(
    parameter int PAT_W  = 5,
    parameter int NBYTES = 32,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [PAT_W-1:0]  pat,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  cnt_in,
    output logic [CNT_W-1:0]  cnt_byte,
    output logic [CNT_W-1:0]  cnt_all
);

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [7:0] PAT_MASK = 8'((1 << PAT_W) - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    logic [IDX_W-1:0]  idx_r;
    logic [PAT_W-1:0]  pat_r;
    logic [7:0]        tail_r;
    logic              vld_r;
    logic              first_r;
    logic [3:0]        m_s;
    logic [3:0]        c_s;
    logic [CNT_W-1:0]  add_in_s;
    logic [CNT_W-1:0]  add_byte_s;
    logic [CNT_W-1:0]  add_all_s;

    // Windows k = 0..8-PAT_W lying wholly inside one byte.
    function automatic logic [3:0] count_in_byte(input logic [7:0] b, input logic [PAT_W-1:0] p);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k <= 8 - PAT_W; k++) begin
            if (((b >> k) & PAT_MASK) == 8'(p)) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Windows of {prev, b} that cover both bit 8 and bit 7, i.e. straddle the byte boundary.
    function automatic logic [3:0] count_cross(input logic [7:0] prev, input logic [7:0] b,
                                               input logic [PAT_W-1:0] p);
        logic [3:0]  n;
        logic [15:0] w;
        n = 4'd0;
        w = {prev, b};
        for (int k = 9 - PAT_W; k <= 7; k++) begin
            if (((w >> k) & {8'd0, PAT_MASK}) == 16'(p)) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Per-byte increments for the byte currently on the read-data bus.
    always_comb begin
        m_s = count_in_byte(mem_rdata, pat_r);
        if (first_r) begin
            c_s = 4'd0;
        end else begin
            c_s = count_cross(tail_r, mem_rdata, pat_r);
        end
        add_in_s = CNT_W'(m_s);
        if (m_s != 4'd0) begin
            add_byte_s = CNT_W'(1);
        end else begin
            add_byte_s = CNT_W'(0);
        end
        add_all_s = CNT_W'(m_s) + CNT_W'(c_s);
    end

    // Scan controller: address issue, one-cycle read pipeline and count accumulation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            idx_r    <= '0;
            pat_r    <= '0;
            tail_r   <= 8'd0;
            vld_r    <= 1'b0;
            first_r  <= 1'b0;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt_in   <= '0;
            cnt_byte <= '0;
            cnt_all  <= '0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (start) begin
                        pat_r    <= pat;
                        mem_addr <= base;
                        mem_rd   <= 1'b1;
                        idx_r    <= '0;
                        vld_r    <= 1'b0;
                        first_r  <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        cnt_in   <= '0;
                        cnt_byte <= '0;
                        cnt_all  <= '0;
                        state_r  <= RUN;
                    end
                end
                RUN: begin
                    // vld_r marks that mem_rdata now carries the byte addressed last cycle.
                    vld_r <= mem_rd;
                    if (mem_rd) begin
                        if (idx_r == IDX_LAST) begin
                            mem_rd <= 1'b0;
                        end else begin
                            idx_r    <= idx_r + IDX_W'(1);
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                    end
                    if (vld_r) begin
                        cnt_in   <= cnt_in + add_in_s;
                        cnt_byte <= cnt_byte + add_byte_s;
                        cnt_all  <= cnt_all + add_all_s;
                        tail_r   <= mem_rdata;
                        first_r  <= 1'b0;
                        if (!mem_rd) begin
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                    mem_rd  <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_engine.sv
// Directed self-checking bench for pattern_scan_engine: default build plus a PAT_W=3, NBYTES=4 build.
module tb_pattern_scan_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  pat;
    logic [7:0]  base;
    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        done;
    logic [15:0] cnt_in;
    logic [15:0] cnt_byte;
    logic [15:0] cnt_all;

    logic        start2;
    logic [2:0]  pat2;
    logic [7:0]  base2;
    logic [7:0]  mem_addr2;
    logic        mem_rd2;
    logic [7:0]  mem_rdata2;
    logic        busy2;
    logic        done2;
    logic [15:0] cnt_in2;
    logic [15:0] cnt_byte2;
    logic [15:0] cnt_all2;

    logic [7:0]  mem [0:255];
    logic [7:0]  addr_log [$];
    int          errs = 0;
    int          checks = 0;
    int          edges;

    pattern_scan_engine dut (
        .clk(clk), .reset(reset), .start(start), .pat(pat), .base(base),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .cnt_in(cnt_in), .cnt_byte(cnt_byte), .cnt_all(cnt_all)
    );

    pattern_scan_engine #(.PAT_W(3), .NBYTES(4), .ADDR_W(8), .CNT_W(16)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .pat(pat2), .base(base2),
        .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2),
        .busy(busy2), .done(done2), .cnt_in(cnt_in2), .cnt_byte(cnt_byte2), .cnt_all(cnt_all2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_rd2) mem_rdata2 <= mem[mem_addr2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int lo, input int n, input logic [7:0] v);
        for (int i = 0; i < n; i++) mem[(lo + i) % 256] = v;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    endtask

    // Accept a start, then count edges until done; optionally pulse a stray start at edge stray_at.
    task automatic run(input logic [4:0] p, input logic [7:0] b, input int stray_at, output int n_edges);
        @(negedge clk);
        pat = p; base = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        addr_log.delete();
        if (mem_rd) addr_log.push_back(mem_addr);
        n_edges = 0;
        while (!done && n_edges < 100) begin
            @(posedge clk);
            #1;
            n_edges++;
            if (mem_rd) addr_log.push_back(mem_addr);
            start = (n_edges == stray_at);
            pat = (n_edges == stray_at) ? ~p : p;
        end
        start = 1'b0;
        check("run_done", {31'd0, done}, 32'd1);
        check("run_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_counts(input string tag, input int ein, input int ebyte, input int eall);
        check({tag, "_in"},   {16'd0, cnt_in},   ein);
        check({tag, "_byte"}, {16'd0, cnt_byte}, ebyte);
        check({tag, "_all"},  {16'd0, cnt_all},  eall);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; pat = 5'd0; base = 8'd0;
        start2 = 1'b0; pat2 = 3'd0; base2 = 8'd0;
        clear_mem();
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_rd", {31'd0, mem_rd}, 32'd0);
        check("rst_addr", {24'd0, mem_addr}, 32'd0);
        check_counts("rst", 0, 0, 0);
        @(negedge clk) reset = 1'b1;

        fill(0, 32, 8'hFF);
        run(5'b11111, 8'h00, -1, edges);
        check("ff_latency", edges, 33);
        check("ff_naddr", addr_log.size(), 32);
        check("ff_rd_off", {31'd0, mem_rd}, 32'd0);
        check("ff_addr_hold", {24'd0, mem_addr}, 32'd31);
        check_counts("ff", 128, 32, 252);

        fill(0, 32, 8'h55);
        run(5'b10101, 8'h00, -1, edges);
        check_counts("x55", 64, 32, 126);

        fill(0, 32, 8'h00);
        run(5'b00000, 8'h00, -1, edges);
        check_counts("zero", 128, 32, 252);

        clear_mem();
        mem[0] = 8'h03; mem[1] = 8'hE0;
        run(5'b11111, 8'h00, -1, edges);
        check_counts("cross", 0, 0, 1);

        clear_mem();
        mem[0] = 8'hF8;
        run(5'b11111, 8'h00, -1, edges);
        check_counts("f8", 1, 1, 1);

        clear_mem();
        fill(8'hF0, 32, 8'h55);
        run(5'b10101, 8'hF0, -1, edges);
        check("wrap_n", addr_log.size(), 32);
        if (addr_log.size() == 32) begin
            check("wrap_a0", {24'd0, addr_log[0]}, 32'hF0);
            check("wrap_a15", {24'd0, addr_log[15]}, 32'hFF);
            check("wrap_a16", {24'd0, addr_log[16]}, 32'h00);
            check("wrap_a31", {24'd0, addr_log[31]}, 32'h0F);
        end
        check_counts("wrap", 64, 32, 126);

        clear_mem();
        fill(0, 32, 8'hFF);
        run(5'b11111, 8'h00, 5, edges);
        check("stray_latency", edges, 33);
        check_counts("stray", 128, 32, 252);

        // Restart from DONE, then reset once idx reaches 10.
        @(negedge clk);
        pat = 5'b11111; base = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_busy", {31'd0, busy}, 32'd1);
        check_counts("restart", 0, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        check("mid_addr", {24'd0, mem_addr}, 32'd10);
        reset = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_rd", {31'd0, mem_rd}, 32'd0);
        check("arst_addr", {24'd0, mem_addr}, 32'd0);
        check_counts("arst", 0, 0, 0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_done", {31'd0, done}, 32'd0);

        run(5'b11111, 8'h00, -1, edges);
        check("fresh_latency", edges, 33);
        check_counts("fresh", 128, 32, 252);

        // Narrow build: PAT_W=3, NBYTES=4 over 0xFF bytes.
        @(negedge clk);
        pat2 = 3'b111; base2 = 8'h00; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
        edges = 0;
        while (!done2 && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("p3_latency", edges, 5);
        check("p3_in", {16'd0, cnt_in2}, 32'd24);
        check("p3_byte", {16'd0, cnt_byte2}, 32'd4);
        check("p3_all", {16'd0, cnt_all2}, 32'd30);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
